// File: rtl/h_sparse_gen.sv
// h_sparse_gen: draws WEIGHT in-range ring indices into an external position RAM.
// Optional duplicate scan over earlier positions is enabled by SPARSE_DUP_CHECK_EN.
module h_sparse_gen #(
    parameter int R_BITS = 10163,
    parameter int WEIGHT = 71,
    parameter int IDX_W  = 14,
    parameter int CNT_W  = 7
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    output logic             done,
    output logic             busy,
    input  logic [IDX_W-1:0] rand_in,
    input  logic             rand_valid,
    output logic             rand_ready,
    output logic             pos_we,
    output logic [CNT_W-1:0] pos_waddr,
    output logic [IDX_W-1:0] pos_wdata,
    output logic [CNT_W-1:0] pos_raddr,
    input  logic [IDX_W-1:0] pos_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CHECK = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LP_WEIGHT = CNT_W'(WEIGHT);
    localparam logic [31:0]      LP_RBITS  = 32'(R_BITS);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [IDX_W-1:0] r_cand;
    logic [IDX_W-1:0] w_cand_nxt;
    logic             w_in_range;

    // 32-bit compare so an R_BITS of exactly 2**IDX_W still works
    assign w_in_range = (32'(rand_in) < LP_RBITS);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign busy       = (r_state != S_IDLE);

`ifdef SPARSE_DUP_CHECK_EN
    logic [CNT_W-1:0] r_ridx;
    logic [CNT_W-1:0] w_ridx_nxt;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_ridx <= '0;
        end else begin
            r_ridx <= w_ridx_nxt;
        end
    end
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^pos_rdata;
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_cand_nxt = r_cand;
`ifdef SPARSE_DUP_CHECK_EN
        w_ridx_nxt = r_ridx;
`endif
        done       = 1'b0;
        rand_ready = 1'b0;
        pos_we     = 1'b0;
        pos_waddr  = '0;
        pos_wdata  = '0;
        pos_raddr  = '0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                rand_ready = 1'b1;
                if (rand_valid) begin
                    w_cand_nxt = rand_in;
                    if (w_in_range) begin
`ifdef SPARSE_DUP_CHECK_EN
                        if (r_cnt == '0) begin
                            w_next = S_WRITE;
                        end else begin
                            w_next     = S_CHECK;
                            w_ridx_nxt = '0;
                        end
`else
                        w_next = S_WRITE;
`endif
                    end
                end
            end
`ifdef SPARSE_DUP_CHECK_EN
            S_CHECK: begin
                // Address k is issued on scan cycle k, its data compared on cycle k+1
                if (r_ridx < r_cnt) begin
                    pos_raddr = r_ridx;
                end
                w_ridx_nxt = r_ridx + CNT_W'(1);
                if ((r_ridx != '0) && (pos_rdata == r_cand)) begin
                    w_next = S_FETCH;
                end else if (r_ridx == r_cnt) begin
                    w_next = S_WRITE;
                end
            end
`endif
            S_WRITE: begin
                pos_we    = 1'b1;
                pos_waddr = r_cnt;
                pos_wdata = r_cand;
                w_cnt_nxt = w_cnt_inc;
                w_next    = (w_cnt_inc == LP_WEIGHT) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_h_sparse_gen.sv
// Self-checking bench for h_sparse_gen (R_BITS=20, WEIGHT=3).
// Behaviour depends on whether SPARSE_DUP_CHECK_EN is defined for the build.
module tb_h_sparse_gen;

    localparam int R  = 20;
    localparam int W  = 3;
    localparam int IW = 5;
    localparam int CW = 4;

    localparam int K_IDLE  = 0;
    localparam int K_FETCH = 1;
    localparam int K_CHK   = 2;
    localparam int K_WR    = 3;
    localparam int K_DONE  = 4;

    typedef struct {
        int k;
        int ra;
        bit rachk;
        int wa;
        int wd;
    } ent_t;

    logic          clk;
    logic          rst_b;
    logic          start;
    logic          done;
    logic          busy;
    logic [IW-1:0] rand_in;
    logic          rand_valid;
    logic          rand_ready;
    logic          pos_we;
    logic [CW-1:0] pos_waddr;
    logic [IW-1:0] pos_wdata;
    logic [CW-1:0] pos_raddr;
    logic [IW-1:0] pos_rdata;

    h_sparse_gen #(
        .R_BITS(R),
        .WEIGHT(W),
        .IDX_W (IW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .rand_in   (rand_in),
        .rand_valid(rand_valid),
        .rand_ready(rand_ready),
        .pos_we    (pos_we),
        .pos_waddr (pos_waddr),
        .pos_wdata (pos_wdata),
        .pos_raddr (pos_raddr),
        .pos_rdata (pos_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [IW-1:0] mem [0:15];

    always @(posedge clk) begin
        if (pos_we) begin
            mem[pos_waddr] <= pos_wdata;
        end
        pos_rdata <= mem[pos_raddr];
    end

    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    int   n_wr   = 0;
    bit   chk_on = 0;
    bit   gaps   = 0;
    bit   spam   = 0;
    bit   s_busy, s_rdy, s_we, s_done;
    int   sq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference model: a timeline of expected cycle kinds per candidate
    bit   m_run = 0;
    int   m_acc[$];
    ent_t m_q[$];
    ent_t m_cur = '{K_IDLE, 0, 1'b0, 0, 0};

    function automatic ent_t mk(int k, int ra, bit rachk, int wa, int wd);
        ent_t e;
        e.k = k; e.ra = ra; e.rachk = rachk; e.wa = wa; e.wd = wd;
        return e;
    endfunction

    task automatic plan(input int c);
        int n;
        int j;
        n = m_acc.size();
        j = -1;
`ifdef SPARSE_DUP_CHECK_EN
        for (int i = 0; i < n; i++) begin
            if (j < 0 && m_acc[i] == c) j = i;
        end
        if (n > 0) begin
            int len;
            len = (j >= 0) ? j + 2 : n + 1;
            for (int k = 0; k < len; k++) begin
                m_q.push_back(mk(K_CHK, k, k < n, 0, 0));
            end
        end
`endif
        if (j < 0) begin
            m_q.push_back(mk(K_WR, 0, 1'b0, n, c));
            m_acc.push_back(c);
            if (n + 1 == W) m_q.push_back(mk(K_DONE, 0, 1'b0, 0, 0));
        end
    endtask

    always @(posedge clk) begin
        if (!rst_b) begin
            m_run = 0;
            m_q.delete();
            m_acc.delete();
            m_cur = mk(K_IDLE, 0, 1'b0, 0, 0);
        end else begin
            if (m_cur.k == K_IDLE && start) begin
                m_run = 1;
                m_acc.delete();
            end
            if (m_cur.k == K_FETCH && rand_valid && int'(rand_in) < R) begin
                plan(int'(rand_in));
            end
            if (m_cur.k == K_DONE) m_run = 0;
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            else m_cur = mk(m_run ? K_FETCH : K_IDLE, 0, 1'b0, 0, 0);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy, m_cur.k != K_IDLE);
            chk("rand_ready", rand_ready, m_cur.k == K_FETCH);
            chk("pos_we", pos_we, m_cur.k == K_WR);
            chk("done", done, m_cur.k == K_DONE);
            if (m_cur.k == K_WR) begin
                chk("pos_waddr", pos_waddr, m_cur.wa);
                chk("pos_wdata", pos_wdata, m_cur.wd);
            end
`ifdef SPARSE_DUP_CHECK_EN
            if (m_cur.k == K_CHK && m_cur.rachk) chk("pos_raddr", pos_raddr, m_cur.ra);
`else
            chk("pos_raddr_zero", pos_raddr, 0);
`endif
            if (done === 1'b1) n_done++;
            if (pos_we === 1'b1) n_wr++;
        end
    end

    task automatic cyc();
        bit hs;
        @(negedge clk);
        hs     = rand_valid && rand_ready;
        s_busy = busy;
        s_rdy  = rand_ready;
        s_we   = pos_we;
        s_done = done;
        @(posedge clk);
        #1;
        if (hs && sq.size() > 0) void'(sq.pop_front());
        start = spam && s_rdy && ($urandom_range(0, 3) == 0);
        if (sq.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            rand_valid = 1'b1;
            rand_in    = IW'(sq[0]);
        end else begin
            rand_valid = 1'b0;
            rand_in    = IW'($urandom);
        end
    endtask

    task automatic run(input bit do_start, input int budget);
        int  d0;
        bit  ok;
        d0 = n_done;
        ok = 0;
        if (do_start) begin
            start = 1'b1;
            cyc();
        end
        for (int i = 0; i < budget && !ok; i++) begin
            cyc();
            if (n_done != d0) ok = 1;
        end
        if (!ok) chk("run_timeout", 0, 1);
    endtask

    task automatic ram3(input string nm, input int e0, input int e1, input int e2);
        chk({nm, "_ram0"}, mem[0], e0);
        chk({nm, "_ram1"}, mem[1], e1);
        chk({nm, "_ram2"}, mem[2], e2);
    endtask

    initial begin
        int w0;
        int d0;
        bit found;
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        bit found;
        rst_b = 1'b0; start = 1'b0; rand_valid = 1'b0; rand_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {done, busy, rand_ready, pos_we, pos_waddr, pos_wdata, pos_raddr}, 0);
        chk_on = 1;
        @(posedge clk);
        #1 rst_b = 1'b1;

        // basic stream with out-of-range and repeated candidates
        sq = '{5, 25, 5, 7, 19};
        w0 = n_wr; d0 = n_done;
        run(1, 200);
`ifdef SPARSE_DUP_CHECK_EN
        ram3("basic", 5, 7, 19);
`else
        ram3("basic", 5, 5, 7);
`endif
        chk("basic_writes", n_wr - w0, 3);
        chk("basic_dones", n_done - d0, 1);
        sq.delete();

        // range boundary: 0 and R-1 accepted, R rejected
        sq = '{0, 19, 20, 1};
        run(1, 200);
        ram3("bound", 0, 19, 1);
        sq.delete();

        // start pulses while busy are ignored
        sq = '{1, 2, 3};
        gaps = 1; spam = 1;
        w0 = n_wr; d0 = n_done;
        run(1, 300);
        spam = 0; gaps = 0; start = 1'b0;
        chk("busy_start_writes", n_wr - w0, 3);
        chk("busy_start_dones", n_done - d0, 1);
        ram3("busy_start", 1, 2, 3);
        sq.delete();

        // reset mid-run (in the scan state when it exists)
        sq = '{3, 4, 5, 6};
        d0 = n_done;
        found = 0;
        start = 1'b1;
        cyc();
        for (int i = 0; i < 50 && !found; i++) begin
            cyc();
`ifdef SPARSE_DUP_CHECK_EN
            if (s_busy && !s_rdy && !s_we && !s_done) found = 1;
`else
            if (s_we) found = 1;
`endif
        end
        chk("reset_target_found", found, 1);
        sq.delete();
        rand_valid = 1'b0;
        rst_b = 1'b0;
        cyc();
        rst_b = 1'b1;
        @(negedge clk);
        chk("midrun_reset_outs", {done, busy, rand_ready, pos_we, pos_waddr, pos_wdata, pos_raddr}, 0);
        chk("midrun_reset_nodone", n_done - d0, 0);
        sq = '{7, 8, 9};
        run(1, 200);
        ram3("after_reset", 7, 8, 9);
        sq.delete();

        // no valid data for 10 cycles: stays in fetch, no writes
        w0 = n_wr;
        start = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("stall_ready", s_rdy, 1);
        end
        chk("stall_writes", n_wr - w0, 0);
        sq = '{10, 11, 12};
        run(0, 200);
        ram3("stall", 10, 11, 12);
        sq.delete();

        // repeated value: rejected only with the duplicate scan
        sq = '{5, 5, 7, 9};
        run(1, 200);
`ifdef SPARSE_DUP_CHECK_EN
        ram3("repeat", 5, 7, 9);
`else
        ram3("repeat", 5, 5, 7);
`endif
        sq.delete();

        // randomized runs with gaps and busy-time start pulses
        for (int r = 0; r < 8; r++) begin
            gaps = 1;
            spam = r[0];
            for (int i = 0; i < 60; i++) sq.push_back(int'($urandom_range(0, 31)));
            run(1, 1500);
            spam = 0; start = 1'b0;
            for (int i = 0; i < W; i++) begin
                chk($sformatf("rand%0d_ram%0d", r, i), mem[i], m_acc[i]);
`ifdef SPARSE_DUP_CHECK_EN
                for (int j = 0; j < i; j++) begin
                    chk($sformatf("rand%0d_distinct%0d_%0d", r, j, i), mem[i] != mem[j], 1);
                end
`endif
            end
            sq.delete();
            gaps = 0;
        end

        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/h_sparse_gen.md
H_SPARSE_GEN -- requirements
Module: h_sparse_gen

Interface
REQ-001 SHALL have parameter R_BITS, default 10163, meaning the ring length; valid indices are 0..R_BITS-1.
REQ-002 SHALL have parameter WEIGHT, default 71, meaning the number of distinct indices generated per run (W/2).
REQ-003 SHALL have parameter IDX_W, default 14, meaning the index and random-word width.
REQ-004 SHALL have parameter CNT_W, default 7, meaning the position-counter and RAM-address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_b, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port start, input, 1, a one-cycle run request from the core controller.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse at run completion.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port rand_in, input, IDX_W, the random candidate word.
REQ-011 SHALL have port rand_valid, input, 1, meaning rand_in is valid.
REQ-012 SHALL have port rand_ready, output, 1, meaning the block consumes rand_in this cycle.
REQ-013 SHALL have port pos_we, input of the external RAM driven as output, 1, the position-RAM write enable.
REQ-014 SHALL have ports pos_waddr (output, CNT_W) and pos_wdata (output, IDX_W), the position-RAM write address and data.
REQ-015 SHALL have port pos_raddr, output, CNT_W, the position-RAM read address.
REQ-016 SHALL have port pos_rdata, input, IDX_W, the RAM read data, valid one cycle after pos_raddr.

Function
REQ-017 SHALL implement the states IDLE, FETCH, CHECK, WRITE and DONE.
REQ-018 IDLE SHALL go to FETCH on the cycle after start=1; while in IDLE, cnt SHALL be cleared to 0.
REQ-019 start SHALL be ignored in every state except IDLE; no restart and no error is raised.
REQ-020 In FETCH, rand_ready SHALL be 1; on a cycle with rand_valid=1 the block latches cand=rand_in.
REQ-021 A candidate with cand >= R_BITS SHALL be rejected; the block stays in FETCH and nothing is written.
REQ-022 A candidate with cand < R_BITS SHALL go to WRITE when cnt=0, and to CHECK otherwise.
REQ-023 In CHECK, pos_raddr SHALL step 0..cnt-1, one address per cycle; each pos_rdata is compared with cand one cycle after its address was issued.
REQ-024 When a compare matches (duplicate), the block SHALL abort CHECK and return to FETCH, discarding cand.
REQ-025 When the last compare does not match, the block SHALL go to WRITE; for cnt>0, CHECK lasts exactly cnt+1 cycles.
REQ-026 In WRITE, the block SHALL assert pos_we=1, pos_waddr=cnt and pos_wdata=cand for one cycle, then increment cnt.
REQ-027 WRITE SHALL go to DONE if the post-increment cnt equals WEIGHT, and to FETCH otherwise.
REQ-028 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; a start arriving in the following IDLE cycle is accepted.
REQ-029 Outside FETCH, rand_ready SHALL be 0, and rand_valid SHALL be ignored.
REQ-030 pos_we SHALL be 0 outside WRITE; exactly WEIGHT writes occur per run, to addresses 0..WEIGHT-1 in order.
REQ-031 Comparisons SHALL be unsigned over the full IDX_W bits; cnt SHALL never exceed WEIGHT.
REQ-032 Unused state encodings SHALL return to IDLE.

Reset
REQ-033 While rst_b=0 at a clock edge, state SHALL be IDLE, cnt=0 and cand=0.
REQ-034 While rst_b=0, the outputs SHALL be done=0, busy=0, rand_ready=0, pos_we=0, pos_waddr=0, pos_wdata=0 and pos_raddr=0.
REQ-035 Reset in any state SHALL abandon the run with no done pulse; RAM contents are don't-care.

Configuration
REQ-036 With SPARSE_DUP_CHECK_EN defined, the CHECK state and the duplicate rejection SHALL be present as specified above.
REQ-037 Without SPARSE_DUP_CHECK_EN, CHECK SHALL be omitted: in-range candidates go directly FETCH->WRITE, and pos_raddr SHALL be held at 0 (the source guarantees distinct values).

Verification (R_BITS=20, WEIGHT=3, macro defined unless stated)
REQ-038 Bench SHALL apply start, then a continuous stream 5,25,5,7,19 -> RAM[0..2]=5,7,19; 25 and 5 are rejected; exactly one done pulse.
REQ-039 Bench SHALL apply a stream 0,19,20 then 1 -> 0 and 19 are accepted (boundary); 20 is rejected; RAM[2]=1.
REQ-040 Bench SHALL assert start while busy -> no effect; the run completes with exactly 3 writes.
REQ-041 Bench SHALL drop rst_b low in CHECK -> next cycle all outputs 0, state IDLE; a new start runs cleanly.
REQ-042 Bench SHALL hold rand_valid low for 10 cycles in FETCH -> the block stays in FETCH with rand_ready=1 and no writes.
REQ-043 Bench SHALL build without the macro and stream 5,5,7 -> RAM[0..2]=5,5,7; done follows the third WRITE by 1 cycle.
